// File: rtl/mem_responder_if.sv
// Request/response bus between a CPU load/store unit and mem_responder.
// The master drives requests and consumes responses; the slave is the responder.
interface mem_responder_if #(
    parameter int ADDR_W = 14
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [2:0]        req_type;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_type, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_type, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding word memory with fixed access latency. It serves
// RV32I-style byte/half/word loads and stores with alignment checking.
// Memory contents survive reset; only the control state is cleared.
module mem_responder #(
    parameter int ADDR_W  = 14,
    parameter int LATENCY = 2
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);
    localparam int WORDS = 2 ** (ADDR_W - 2);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [2:0]        typ;
    } req_t;

    state_t     state;
    logic [3:0] cnt;
    req_t       rq;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [3:0][7:0] mem [WORDS];

    logic [ADDR_W-3:0] word_idx;
    logic [3:0][7:0]   rd_word;
    logic [3:0][7:0]   wr_word;
    logic [3:0]        byte_en;
    logic              acc_err;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [31:0]       ld_data;
    logic              do_access;

    assign word_idx  = rq.addr[ADDR_W-1:2];
    assign rd_word   = mem[word_idx];
    assign do_access = (state == WAIT) && (cnt == 4'd0);

    // Decode the latched request: legality, byte lanes, store word, load result
    always_comb begin
        acc_err  = 1'b0;
        byte_en  = 4'b1111;
        wr_word  = rq.wdata;
        sel_byte = rd_word[rq.addr[1:0]];
        sel_half = rq.addr[1] ? rd_word[3:2] : rd_word[1:0];
        ld_data  = rd_word;

        case (rq.typ)
            3'b000:  acc_err = 1'b0;
            3'b001:  acc_err = rq.addr[0];
            3'b010:  acc_err = |rq.addr[1:0];
            3'b100:  acc_err = rq.we;
            3'b101:  acc_err = rq.we | rq.addr[0];
            default: acc_err = 1'b1;
        endcase

        // Store data is replicated across lanes; byte_en picks the live ones
        case (rq.typ[1:0])
            2'b00: begin
                byte_en = 4'b0001 << rq.addr[1:0];
                wr_word = {4{rq.wdata[7:0]}};
            end
            2'b01: begin
                byte_en = rq.addr[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{rq.wdata[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wr_word = rq.wdata;
            end
        endcase

        case (rq.typ)
            3'b000:  ld_data = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  ld_data = {24'd0, sel_byte};
            3'b001:  ld_data = {{16{sel_half[15]}}, sel_half};
            3'b101:  ld_data = {16'd0, sel_half};
            default: ld_data = rd_word;
        endcase
    end

    // Byte-lane store on the access edge; legal stores only, never reset
    always_ff @(posedge clk) begin
        if (do_access && rq.we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[word_idx][i] <= wr_word[i];
            end
        end
    end

    // Control FSM: accept, count down the latency, hold the response until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rq      <= '0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        rq.we    <= bus.req_we;
                        rq.addr  <= bus.req_addr;
                        rq.wdata <= bus.req_wdata;
                        rq.typ   <= bus.req_type;
                        cnt      <= 4'(LATENCY - 1);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        err_q   <= acc_err;
                        rdata_q <= (acc_err || rq.we) ? 32'd0 : ld_data;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    // Returning to IDLE here means no accept can share this edge
                    if (bus.rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE) && !rst;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, hand-built stall/reset
// sequences, then random traffic checked against a byte-array memory model.
module tb_mem_responder;
    localparam int AW  = 14;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(AW)) bus();
    mem_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] mb [0:(1<<AW)-1];

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [31:0]   wd;
        logic [2:0]    t;
        logic [31:0]   rd;
        logic          e;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Reference: access size from funct3, alignment by modulo, bytes in an array
    task automatic model(input logic we, input logic [AW-1:0] a, input logic [31:0] wd,
                         input logic [2:0] t, output logic [31:0] rd, output logic e);
        int sz;
        logic [31:0] v;
        sz = (t[1:0] == 2'd0) ? 1 : (t[1:0] == 2'd1) ? 2 : 4;
        e  = (t == 3'd3) || (t >= 3'd6) || (we && t[2]) || ((int'(a) % sz) != 0);
        rd = 32'd0;
        if (!e) begin
            if (we) begin
                for (int i = 0; i < sz; i++) mb[int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < sz; i++) v = v | (32'(mb[int'(a) + i]) << (8 * i));
                if (!t[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
                rd = v;
            end
        end
    endtask

    // One full transaction; the request bus carries junk while busy to show
    // the responder neither re-samples nor accepts on the completing edge.
    task automatic do_req(input string nm, input logic we, input logic [AW-1:0] a,
                          input logic [31:0] wd, input logic [2:0] t, input int stall,
                          output logic [31:0] rd, output logic e);
        int lat;
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({nm, " req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_type  = t;
        @(posedge clk);
        #1;
        bus.req_we    = 1'b1;
        bus.req_addr  = AW'($urandom);
        bus.req_wdata = $urandom;
        bus.req_type  = 3'($urandom);
        chk({nm, " busy"}, 32'(bus.req_ready), 32'd0);
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(LAT));
        rd = bus.rsp_rdata;
        e  = bus.rsp_err;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            chk({nm, " hold valid"}, 32'(bus.rsp_valid), 32'd1);
            chk({nm, " hold rdata"}, bus.rsp_rdata, rd);
            chk({nm, " hold ready"}, 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        chk({nm, " rsp done"}, 32'(bus.rsp_valid), 32'd0);
        chk({nm, " no accept"}, 32'(bus.req_ready), 32'd1);
    endtask

    task automatic run(input string nm, input logic we, input logic [AW-1:0] a,
                       input logic [31:0] wd, input logic [2:0] t, input int stall,
                       input logic [31:0] exp_rd, input logic exp_e);
        logic [31:0] rd;
        logic e;
        do_req(nm, we, a, wd, t, stall, rd, e);
        chk({nm, " rdata"}, rd, exp_rd);
        chk({nm, " err"}, 32'(e), 32'(exp_e));
    endtask

    task automatic add(input logic we, input logic [AW-1:0] a, input logic [31:0] wd,
                       input logic [2:0] t, input logic [31:0] rd, input logic e);
        vec_t v;
        v.we = we; v.a = a; v.wd = wd; v.t = t; v.rd = rd; v.e = e;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, exp_rd;
        logic e, exp_e;
        logic we;
        logic [AW-1:0] a;
        logic [31:0] wd;
        logic [2:0] t;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = 32'd0;
        bus.req_type  = 3'd0;
        bus.rsp_ready = 1'b0;

        // Reset state
        #2;
        chk("rst req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst rsp_err",   32'(bus.rsp_err), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post-rst req_ready", 32'(bus.req_ready), 32'd1);

        // Directed vectors
        add(1, 14'h0010, 32'hDEADBEEF, 3'b010, 32'h0,        0);
        add(0, 14'h0010, 32'h0,        3'b010, 32'hDEADBEEF, 0);
        add(0, 14'h0013, 32'h0,        3'b000, 32'hFFFFFFDE, 0);
        add(0, 14'h0013, 32'h0,        3'b100, 32'h000000DE, 0);
        add(0, 14'h0012, 32'h0,        3'b001, 32'hFFFFDEAD, 0);
        add(0, 14'h0010, 32'h0,        3'b101, 32'h0000BEEF, 0);
        add(1, 14'h0011, 32'h00000012, 3'b000, 32'h0,        0);
        add(0, 14'h0010, 32'h0,        3'b010, 32'hDEAD12EF, 0);
        add(1, 14'h0020, 32'h11223344, 3'b010, 32'h0,        0);
        add(1, 14'h0022, 32'h00000001, 3'b010, 32'h0,        1);
        add(0, 14'h0020, 32'h0,        3'b010, 32'h11223344, 0);
        add(0, 14'h0020, 32'h0,        3'b011, 32'h0,        1);
        add(1, 14'h0024, 32'h0,        3'b010, 32'h0,        0);
        add(1, 14'h0026, 32'h1234A5A5, 3'b001, 32'h0,        0);
        add(0, 14'h0024, 32'h0,        3'b010, 32'hA5A50000, 0);
        add(1, 14'h0024, 32'h000000FF, 3'b100, 32'h0,        1);
        add(0, 14'h0025, 32'h0,        3'b101, 32'h0,        1);
        add(0, 14'h0024, 32'h0,        3'b010, 32'hA5A50000, 0);
        for (int i = 0; i < tbl.size(); i++)
            run($sformatf("vec%0d", i), tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].t, 0,
                tbl[i].rd, tbl[i].e);

        // Response held for five cycles with the consumer stalled
        run("stall", 0, 14'h0010, 32'h0, 3'b010, 5, 32'hDEAD12EF, 0);

        // Reset while a store is waiting: store dropped, old contents kept
        run("pre37", 1, 14'h0030, 32'hCAFEF00D, 3'b010, 0, 32'h0, 0);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 14'h0030;
        bus.req_wdata = 32'h00000055;
        bus.req_type  = 3'b010;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst release ready", 32'(bus.req_ready), 32'd1);
        run("post37", 0, 14'h0030, 32'h0, 3'b010, 0, 32'hCAFEF00D, 0);

        // Reset while a response is pending clears it at once
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 14'h0030;
        bus.req_type  = 3'b010;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        chk("resprst valid before", 32'(bus.rsp_valid), 32'd1);
        chk("resprst rdata before", bus.rsp_rdata, 32'hCAFEF00D);
        #2;
        rst = 1'b1;
        #1;
        chk("resprst valid", 32'(bus.rsp_valid), 32'd0);
        chk("resprst rdata", bus.rsp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Random traffic in a preloaded region against the byte model
        for (int i = 0; i < 16; i++) begin
            a  = AW'(14'h0100 + 4 * i);
            wd = $urandom;
            model(1'b1, a, wd, 3'b010, exp_rd, exp_e);
            run("preload", 1'b1, a, wd, 3'b010, 0, exp_rd, exp_e);
        end
        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = AW'(14'h0100 + $urandom_range(0, 63));
            wd = $urandom;
            t  = 3'($urandom_range(0, 7));
            model(we, a, wd, t, exp_rd, exp_e);
            do_req($sformatf("rnd%0d", i), we, a, wd, t, $urandom_range(0, 2), rd, e);
            chk($sformatf("rnd%0d rdata", i), rd, exp_rd);
            chk($sformatf("rnd%0d err", i), 32'(e), 32'(exp_e));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
